vdp_sram_mp: RTL and testbench
==============================

VDP_SRAM_MP -- requirements
Module: vdp_sram_mp

Interface
REQ-001 Parameter AW, default 14: SRAM/VRAM address width.
REQ-002 Parameter DW, default 8: data width.
REQ-003 Parameter NPORT, default 2, legal range 1..8: number of requester ports.
REQ-004 Parameter WAIT_CYC, default 0, legal range 0..7: extra strobe cycles per access.
REQ-005 clk40m  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 vram_req  in  NPORT  per-port request level; held until that port's ack.
REQ-008 vram_wr  in  NPORT  per-port write (1) / read (0).
REQ-009 vram_addr  in  NPORT*AW  per-port address, flattened, port 0 in LSBs.
REQ-010 vram_wdata  in  NPORT*DW  per-port write data, flattened, port 0 in LSBs.
REQ-011 vram_ack  out  NPORT  one-cycle completion pulse, one-hot or zero.
REQ-012 vram_rdata  out  DW  shared read data; valid in the cycle the granted port's ack is high.
REQ-013 sram_a  out  AW  SRAM address.
REQ-014 sram_d  inout  DW  SRAM data bus; driven only during writes, else high-Z.
REQ-015 sram_oe_n  out  1  SRAM output enable, active low.
REQ-016 sram_we_n  out  1  SRAM write enable, active low.

Function
REQ-017 FSM states: IDLE, SETUP, STROBE, HOLD; any other encoding SHALL go to IDLE next cycle with all strobes deasserted, sram_d released, ack 0.
REQ-018 IDLE: if any vram_req bit is high, grant one port round-robin, latch its wr/addr/wdata, drive sram_a, go to SETUP; otherwise stay in IDLE.
REQ-019 Round-robin: search starts at the port after the last granted port, wrapping NPORT-1 to 0; after reset, port 0 has highest priority.
REQ-020 SETUP (1 cycle): read: sram_oe_n=0; write: sram_d driven with latched wdata, sram_we_n stays 1.
REQ-021 STROBE (WAIT_CYC+1 cycles, counted by a 3-bit down-counter): read: sram_oe_n=0; write: sram_we_n=0, data driven.
REQ-022 Read data SHALL be captured from sram_d on the edge leaving STROBE.
REQ-023 HOLD (1 cycle): sram_oe_n=1, sram_we_n=1; write data still driven (hold time); vram_ack bit of granted port =1; then IDLE.
REQ-024 sram_d SHALL be released at the edge leaving HOLD; IDLE never drives sram_d.
REQ-025 Latency: req sampled at IDLE edge k -> ack high in the cycle after edge k+2+WAIT_CYC; throughput one access per WAIT_CYC+4 cycles.
REQ-026 sram_a and latched request SHALL stay stable from SETUP through HOLD regardless of requester inputs.
REQ-027 A requester drops req at the edge ending its ack cycle; req still high in the following IDLE counts as a new request.
REQ-028 Requests from ungranted ports wait without loss; no port is skipped while requesting (starvation bound NPORT-1 accesses).
REQ-029 vram_rdata SHALL hold its last captured value until the next read capture.

Reset
REQ-030 While rst is high at a clock edge: state=IDLE, sram_oe_n=1, sram_we_n=1, sram_d high-Z, vram_ack=0, vram_rdata=0, sram_a=0, last-grant=NPORT-1.
REQ-031 Reset asserted mid-access SHALL abort it: no ack issued, strobes high on the next cycle.

Structure
REQ-032 Shared package vdp_sram_pkg SHALL hold the state enumeration and parameter defaults (AW, DW, NPORT, WAIT_CYC).
REQ-033 Round-robin grant logic SHALL be a sub-module vdp_rr_arb (NPORT-wide req in, one-hot grant plus last-grant register).

Verification
REQ-034 NPORT=2, WAIT_CYC=0: port 0 writes 0x5A at 0x1234 -> we_n low exactly 1 cycle, data driven SETUP..HOLD, ack[0] 3 cycles after sample.
REQ-035 Port 1 reads 0x1234 from SRAM model -> oe_n low 2 cycles, rdata=0x5A with ack[1]=1.
REQ-036 Both ports request continuously -> grants alternate 0,1,0,1; each ack spaced 4 cycles apart.
REQ-037 WAIT_CYC=3 write -> we_n low 4 cycles, ack 6 cycles after sample.
REQ-038 rst pulsed during STROBE of a write -> we_n=1, sram_d high-Z next cycle, no ack; next request granted to port 0.

Source files
------------

// File: rtl/vdp_sram_pkg.sv
// Shared types and parameter defaults for the multi-port VRAM/SRAM access controller.
package vdp_sram_pkg;

  localparam int AW_DEF       = 14;
  localparam int DW_DEF       = 8;
  localparam int NPORT_DEF    = 2;
  localparam int WAIT_CYC_DEF = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Width of a port index; a single-port build still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vdp_rr_arb.sv
// Round-robin arbiter: one-hot grant, searching from the port after the last granted one.
module vdp_rr_arb
  import vdp_sram_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int IW    = idx_w(NPORT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic             adv,
  output logic [NPORT-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic [IW-1:0] pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = last_q;
    any     = 1'b0;
    pos     = '0;
    for (int i = 1; i <= NPORT; i++) begin
      pos = IW'((int'(last_q) + i) % NPORT);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
      end
    end
    last_d = (adv && any) ? gnt_idx : last_q;
  end

  // Resetting to the top port makes port 0 the first one searched.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(NPORT - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/vdp_sram_mp.sv
// Multi-port SRAM controller: arbitrates requesters and runs an IDLE/SETUP/STROBE/HOLD cycle.
module vdp_sram_mp
  import vdp_sram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int NPORT    = NPORT_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic                clk40m,
  input  logic                rst,
  input  logic [NPORT-1:0]    vram_req,
  input  logic [NPORT-1:0]    vram_wr,
  input  logic [NPORT*AW-1:0] vram_addr,
  input  logic [NPORT*DW-1:0] vram_wdata,
  output logic [NPORT-1:0]    vram_ack,
  output logic [DW-1:0]       vram_rdata,
  output logic [AW-1:0]       sram_a,
  inout  wire  [DW-1:0]       sram_d,
  output logic                sram_oe_n,
  output logic                sram_we_n
);

  localparam int IW = idx_w(NPORT);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              drive_q, drive_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [NPORT-1:0]  ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [NPORT-1:0]  gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [AW-1:0]     addr_arr  [NPORT];
  logic [DW-1:0]     wdata_arr [NPORT];

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      addr_arr[p]  = vram_addr[p*AW +: AW];
      wdata_arr[p] = vram_wdata[p*DW +: DW];
    end
  end

  vdp_rr_arb #(
    .NPORT (NPORT),
    .IW    (IW)
  ) u_arb (
    .clk     (clk40m),
    .rst     (rst),
    .req     (vram_req),
    .adv     (state_q == ST_IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Strobes are registered so each phase's outputs appear in the cycle of that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gidx_d  = gidx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    drive_d = drive_q;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ack_d   = '0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        drive_d = 1'b0;
        if (gnt_any) begin
          state_d = ST_SETUP;
          gidx_d  = gnt_idx;
          wr_d    = vram_wr[gnt_idx];
          addr_d  = addr_arr[gnt_idx];
          wdata_d = wdata_arr[gnt_idx];
          drive_d = vram_wr[gnt_idx];
          oe_n_d  = vram_wr[gnt_idx];
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = 3'(WAIT_CYC);
        oe_n_d  = wr_q;
        we_n_d  = !wr_q;
      end
      ST_STROBE: begin
        oe_n_d = wr_q;
        we_n_d = !wr_q;
        if (cnt_q == 3'd0) begin
          state_d       = ST_HOLD;
          oe_n_d        = 1'b1;
          we_n_d        = 1'b1;
          ack_d[gidx_q] = 1'b1;
          if (!wr_q) begin
            rdata_d = sram_d;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        drive_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk40m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drive_q <= 1'b0;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ack_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      drive_q <= drive_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk40m) begin
    cnt_q   <= cnt_d;
    gidx_q  <= gidx_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  assign sram_d     = drive_q ? wdata_q : {DW{1'bz}};
  assign sram_a     = addr_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign vram_ack   = ack_q;
  assign vram_rdata = rdata_q;

endmodule

// File: tb/tb_vdp_sram_mp.sv
// Directed bench: two controller instances (WAIT_CYC 0 and 3), each with a simple SRAM model.
module tb_vdp_sram_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req0, wr0, ack0;
  logic [27:0] addr0;
  logic [15:0] wdata0;
  logic [7:0]  rdata0;
  logic [13:0] a0;
  tri1  [7:0]  d0;
  logic        oe0, we0;

  logic [1:0]  req3, wr3, ack3;
  logic [27:0] addr3;
  logic [15:0] wdata3;
  logic [7:0]  rdata3;
  logic [13:0] a3;
  tri1  [7:0]  d3;
  logic        oe3, we3;

  logic [7:0] mem0 [0:16383];
  logic [7:0] mem3 [0:16383];

  int checks = 0;
  int errors = 0;
  int lowcnt;

  vdp_sram_mp #(.AW(14), .DW(8), .NPORT(2), .WAIT_CYC(0)) dut0 (
    .clk40m(clk), .rst(rst), .vram_req(req0), .vram_wr(wr0), .vram_addr(addr0),
    .vram_wdata(wdata0), .vram_ack(ack0), .vram_rdata(rdata0), .sram_a(a0),
    .sram_d(d0), .sram_oe_n(oe0), .sram_we_n(we0));

  vdp_sram_mp #(.AW(14), .DW(8), .NPORT(2), .WAIT_CYC(3)) dut3 (
    .clk40m(clk), .rst(rst), .vram_req(req3), .vram_wr(wr3), .vram_addr(addr3),
    .vram_wdata(wdata3), .vram_ack(ack3), .vram_rdata(rdata3), .sram_a(a3),
    .sram_d(d3), .sram_oe_n(oe3), .sram_we_n(we3));

  // Asynchronous-read SRAM models; writes land on a clock edge while we_n is low.
  assign d0 = (!oe0 && we0) ? mem0[a0] : 8'bz;
  assign d3 = (!oe3 && we3) ? mem3[a3] : 8'bz;

  always @(posedge clk) begin
    if (!we0) mem0[a0] <= d0;
    if (!we3) mem3[a3] <= d3;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0 = '0; wr0 = '0; addr0 = '0; wdata0 = '0;
    req3 = '0; wr3 = '0; addr3 = '0; wdata3 = '0;
    mem0[14'h0010] = 8'h11;
    mem0[14'h0020] = 8'h22;
    tick;
    tick;
    chk("rst_oe", oe0, 1'b1);
    chk("rst_we", we0, 1'b1);
    chk("rst_ack", ack0, 2'b00);
    chk("rst_rdata", rdata0, 8'h00);
    chk("rst_a", a0, 14'h0000);
    chk("rst_d", d0, 8'hFF);
    rst = 1'b0;
    tick;

    // port 0 writes 0x5A to 0x1234
    req0 = 2'b01; wr0 = 2'b01; addr0 = {14'h0000, 14'h1234}; wdata0 = {8'h00, 8'h5A};
    lowcnt = 0;
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (!we0) lowcnt++;
      chk("wr_ack", ack0, (c == 3) ? 2'b01 : 2'b00);
      chk("wr_d", d0, (c <= 3) ? 8'h5A : 8'hFF);
      if (c <= 3) chk("wr_a", a0, 14'h1234);
      if (c == 3) req0 = 2'b00;
    end
    chk("wr_we_cycles", lowcnt, 1);
    chk("wr_mem", mem0[14'h1234], 8'h5A);

    // port 1 reads it back
    req0 = 2'b10; wr0 = 2'b00; addr0 = {14'h1234, 14'h0000};
    lowcnt = 0;
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (!oe0) lowcnt++;
      chk("rd_ack", ack0, (c == 3) ? 2'b10 : 2'b00);
      if (c >= 3) chk("rd_rdata", rdata0, 8'h5A);
      if (c == 3) req0 = 2'b00;
    end
    chk("rd_oe_cycles", lowcnt, 2);

    // both ports request continuously: grants alternate, ack every 4 cycles
    req0 = 2'b11; wr0 = 2'b00; addr0 = {14'h0020, 14'h0010};
    for (int c = 1; c <= 16; c++) begin
      tick;
      chk("rr_ack", ack0, (c % 4 == 3) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
      if (c % 4 == 3) chk("rr_rdata", rdata0, ((c / 4) % 2 == 0) ? 8'h11 : 8'h22);
      if (c == 15) req0 = 2'b00;
    end

    // reset during the strobe of a write aborts it
    req0 = 2'b01; wr0 = 2'b01; addr0 = {14'h0000, 14'h0100}; wdata0 = {8'h00, 8'hC3};
    tick;
    tick;
    chk("abort_we_low", we0, 1'b0);
    rst = 1'b1;
    req0 = 2'b00;
    tick;
    chk("abort_we", we0, 1'b1);
    chk("abort_oe", oe0, 1'b1);
    chk("abort_d", d0, 8'hFF);
    chk("abort_ack", ack0, 2'b00);
    chk("abort_a", a0, 14'h0000);
    rst = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      tick;
      chk("abort_noack", ack0, 2'b00);
    end
    req0 = 2'b11; wr0 = 2'b00; addr0 = {14'h0020, 14'h0010};
    for (int c = 1; c <= 3; c++) begin
      tick;
      chk("post_rst_ack", ack0, (c == 3) ? 2'b01 : 2'b00);
      if (c == 3) begin
        chk("post_rst_rdata", rdata0, 8'h11);
        req0 = 2'b00;
      end
    end
    tick;

    // WAIT_CYC=3 write, address inputs disturbed mid-access
    req3 = 2'b01; wr3 = 2'b01; addr3 = {14'h0000, 14'h0042}; wdata3 = {8'h00, 8'h96};
    lowcnt = 0;
    for (int c = 1; c <= 7; c++) begin
      tick;
      if (!we3) lowcnt++;
      chk("w3_ack", ack3, (c == 6) ? 2'b01 : 2'b00);
      if (c <= 6) begin
        chk("w3_a", a3, 14'h0042);
        chk("w3_d", d3, 8'h96);
      end
      if (c == 2) begin
        addr3 = {14'h3FFF, 14'h3FFF};
        wdata3 = {8'hFF, 8'h00};
      end
      if (c == 6) req3 = 2'b00;
      if (c == 7) chk("w3_release", d3, 8'hFF);
    end
    chk("w3_we_cycles", lowcnt, 4);
    chk("w3_mem", mem3[14'h0042], 8'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
